// File: rtl/row_fetch_ctrl.sv
// Row fetch controller: walks one output row's three input rows in PIXELS_IN_ROW-pixel chunks
// and hands each chunk plus its register-fill metadata downstream. Optional macro: ROW_FETCH_PREFETCH_EN.
module row_fetch_ctrl #(
    parameter int PIXELS_IN_ROW  = 32,
    parameter int SHIFT_REGS_NUM = 70,
    parameter int ADDR_W         = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [3:0]                   k,
    input  logic [3:0]                   s,
    input  logic [3:0]                   pad,
    input  logic [15:0]                  row_width,
    input  logic [ADDR_W-1:0]            base_addr,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [PIXELS_IN_ROW*8-1:0]   rd_data1,
    input  logic [PIXELS_IN_ROW*8-1:0]   rd_data2,
    input  logic [PIXELS_IN_ROW*8-1:0]   rd_data3,
    output logic [PIXELS_IN_ROW*8-1:0]   row1_pixels_32,
    output logic [PIXELS_IN_ROW*8-1:0]   row2_pixels_32,
    output logic [PIXELS_IN_ROW*8-1:0]   row3_pixels_32,
    output logic [15:0]                  row1_slab_2,
    output logic [15:0]                  row2_slab_2,
    output logic [15:0]                  row3_slab_2,
    output logic [3:0]                   west_pad,
    output logic [3:0]                   slab_num,
    output logic [3:0]                   east_pad,
    output logic [15:0]                  reg_start_idx,
    output logic [15:0]                  reg_end_idx,
    output logic                         fill_valid,
    input  logic                         fill_ready,
    output logic                         busy,
    output logic                         done
);
    localparam int DW = PIXELS_IN_ROW * 8;
    localparam logic [15:0] CHUNK = 16'(PIXELS_IN_ROW);

    typedef enum logic [2:0] {IDLE, READ, WAIT, HOLD, FIN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         k_q, k_d, pad_q, pad_d;
    logic [ADDR_W-1:0]  base_q, base_d, rd_addr_q, rd_addr_d;
    logic [15:0]        n_q, n_d, rem_q, rem_d, c_q, c_d;
    logic               rd_en_q, rd_en_d, fill_valid_q, fill_valid_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [DW-1:0]      pix_q [3];
    logic [DW-1:0]      pix_d [3];
    logic [15:0]        slab_q [3];
    logic [15:0]        slab_d [3];
    logic [3:0]         west_q, west_d, slab_num_q, slab_num_d, east_q, east_d;
    logic [15:0]        start_idx_q, start_idx_d, end_idx_q, end_idx_d;
`ifdef ROW_FETCH_PREFETCH_EN
    logic               pend_q, pend_d, skid_valid_q, skid_valid_d;
    logic [DW-1:0]      skid_q [3];
    logic [DW-1:0]      skid_d [3];
`endif

    logic [DW-1:0]      rd_data_a [3];
    logic [DW-1:0]      src;
    logic [15:0]        sn_w, chunk_c, start_idx_w, rem_left;
    logic               first_chunk;
    logic               unused_s;

    assign unused_s     = ^s;
    assign rd_data_a[0] = rd_data1;
    assign rd_data_a[1] = rd_data2;
    assign rd_data_a[2] = rd_data3;

    function automatic logic [7:0] pick(input logic [DW-1:0] w, input logic [15:0] idx);
        pick = 8'd0;
        for (int p = 0; p < PIXELS_IN_ROW; p++)
            if (idx == 16'(p)) pick = w[p*8 +: 8];
    endfunction

    always_comb begin
        // Slab depth is k-1, capped at two carried pixels
        sn_w        = (k_q >= 4'd3) ? 16'd2 : ((k_q == 4'd2) ? 16'd1 : 16'd0);
        chunk_c     = (rem_q > CHUNK) ? CHUNK : rem_q;
        first_chunk = (n_q == 16'd0);
        start_idx_w = first_chunk ? ({12'd0, pad_q} + 16'd1) : (sn_w + 16'd1);
        rem_left    = rem_q - c_q;
        src         = '0;

        state_d      = state_q;
        k_d          = k_q;
        pad_d        = pad_q;
        base_d       = base_q;
        n_d          = n_q;
        rem_d        = rem_q;
        c_d          = c_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        pix_d        = pix_q;
        slab_d       = slab_q;
        west_d       = west_q;
        slab_num_d   = slab_num_q;
        east_d       = east_q;
        start_idx_d  = start_idx_q;
        end_idx_d    = end_idx_q;
        fill_valid_d = fill_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef ROW_FETCH_PREFETCH_EN
        pend_d       = rd_en_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d    = k;
                    pad_d  = pad;
                    base_d = base_addr;
                    n_d    = 16'd0;
                    rem_d  = row_width;
                    for (int r = 0; r < 3; r++) slab_d[r] = 16'd0;
                    if (row_width == 16'd0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_addr;
                        busy_d    = 1'b1;
                    end
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                for (int r = 0; r < 3; r++) begin
`ifdef ROW_FETCH_PREFETCH_EN
                    src = skid_valid_q ? skid_q[r] : rd_data_a[r];
`else
                    src = rd_data_a[r];
`endif
                    for (int p = 0; p < PIXELS_IN_ROW; p++)
                        pix_d[r][p*8 +: 8] = (p < int'(chunk_c)) ? src[p*8 +: 8] : 8'd0;
                end
                c_d          = chunk_c;
                west_d       = first_chunk ? pad_q : 4'd0;
                slab_num_d   = first_chunk ? 4'd0 : sn_w[3:0];
                east_d       = (rem_q <= CHUNK) ? pad_q : 4'd0;
                start_idx_d  = start_idx_w;
                end_idx_d    = start_idx_w + chunk_c - 16'd1;
                fill_valid_d = 1'b1;
                state_d      = HOLD;
`ifdef ROW_FETCH_PREFETCH_EN
                skid_valid_d = 1'b0;
                if (rem_q > CHUNK) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q + n_q[ADDR_W-1:0] + ADDR_W'(1);
                end
`endif
            end
            HOLD: begin
`ifdef ROW_FETCH_PREFETCH_EN
                // Prefetched data lands while the current chunk may still be stalled
                if (pend_q) begin
                    skid_d       = rd_data_a;
                    skid_valid_d = 1'b1;
                end
`endif
                if (fill_ready) begin
                    fill_valid_d = 1'b0;
                    rem_d        = rem_left;
                    n_d          = n_q + 16'd1;
                    for (int r = 0; r < 3; r++) begin
                        case (sn_w)
                            16'd2:   slab_d[r] = {pick(pix_q[r], c_q - 16'd1), pick(pix_q[r], c_q - 16'd2)};
                            16'd1:   slab_d[r] = {8'd0, pick(pix_q[r], c_q - 16'd1)};
                            default: slab_d[r] = 16'd0;
                        endcase
                    end
                    if (rem_left != 16'd0) begin
`ifdef ROW_FETCH_PREFETCH_EN
                        state_d = WAIT;
`else
                        state_d   = READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_q + n_q[ADDR_W-1:0] + ADDR_W'(1);
`endif
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            pad_q        <= '0;
            base_q       <= '0;
            n_q          <= '0;
            rem_q        <= '0;
            c_q          <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            west_q       <= '0;
            slab_num_q   <= '0;
            east_q       <= '0;
            start_idx_q  <= '0;
            end_idx_q    <= '0;
            fill_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                pix_q[r]  <= '0;
                slab_q[r] <= '0;
            end
`ifdef ROW_FETCH_PREFETCH_EN
            pend_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            for (int r = 0; r < 3; r++) skid_q[r] <= '0;
`endif
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            pad_q        <= pad_d;
            base_q       <= base_d;
            n_q          <= n_d;
            rem_q        <= rem_d;
            c_q          <= c_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            west_q       <= west_d;
            slab_num_q   <= slab_num_d;
            east_q       <= east_d;
            start_idx_q  <= start_idx_d;
            end_idx_q    <= end_idx_d;
            fill_valid_q <= fill_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            for (int r = 0; r < 3; r++) begin
                pix_q[r]  <= pix_d[r];
                slab_q[r] <= slab_d[r];
            end
`ifdef ROW_FETCH_PREFETCH_EN
            pend_q       <= pend_d;
            skid_valid_q <= skid_valid_d;
            for (int r = 0; r < 3; r++) skid_q[r] <= skid_d[r];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && fill_valid_q)
            assert (start_idx_q >= 16'd1 && end_idx_q <= 16'(SHIFT_REGS_NUM));
    end

    assign rd_en          = rd_en_q;
    assign rd_addr        = rd_addr_q;
    assign row1_pixels_32 = pix_q[0];
    assign row2_pixels_32 = pix_q[1];
    assign row3_pixels_32 = pix_q[2];
    assign row1_slab_2    = slab_q[0];
    assign row2_slab_2    = slab_q[1];
    assign row3_slab_2    = slab_q[2];
    assign west_pad       = west_q;
    assign slab_num       = slab_num_q;
    assign east_pad       = east_q;
    assign reg_start_idx  = start_idx_q;
    assign reg_end_idx    = end_idx_q;
    assign fill_valid     = fill_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_row_fetch_ctrl.sv
// Bench for row_fetch_ctrl: a bank model answers reads, and each accepted chunk is compared
// against chunk/slab/metadata values derived from the bank contents and the row configuration.
module tb_row_fetch_ctrl;
`ifdef ROW_FETCH_PREFETCH_EN
    localparam int GAP = 2;
    localparam int PF  = 1;
`else
    localparam int GAP = 3;
    localparam int PF  = 0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, fill_ready;
    logic [3:0]   k, s, pad;
    logic [15:0]  row_width;
    logic [9:0]   base_addr;
    logic         rd_en;
    logic [9:0]   rd_addr;
    logic [255:0] rd_data1, rd_data2, rd_data3;
    logic [255:0] row1_pixels_32, row2_pixels_32, row3_pixels_32;
    logic [15:0]  row1_slab_2, row2_slab_2, row3_slab_2;
    logic [3:0]   west_pad, slab_num, east_pad;
    logic [15:0]  reg_start_idx, reg_end_idx;
    logic         fill_valid, busy, done;

    logic [255:0] row_pix [3];
    logic [15:0]  row_slab [3];
    logic [255:0] bank [3][1024];
    int n_checks = 0;
    int n_pass   = 0;

    assign row_pix[0]  = row1_pixels_32;
    assign row_pix[1]  = row2_pixels_32;
    assign row_pix[2]  = row3_pixels_32;
    assign row_slab[0] = row1_slab_2;
    assign row_slab[1] = row2_slab_2;
    assign row_slab[2] = row3_slab_2;

    row_fetch_ctrl #(.PIXELS_IN_ROW(32), .SHIFT_REGS_NUM(70), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .k(k), .s(s), .pad(pad),
        .row_width(row_width), .base_addr(base_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
        .row1_pixels_32(row1_pixels_32), .row2_pixels_32(row2_pixels_32), .row3_pixels_32(row3_pixels_32),
        .row1_slab_2(row1_slab_2), .row2_slab_2(row2_slab_2), .row3_slab_2(row3_slab_2),
        .west_pad(west_pad), .slab_num(slab_num), .east_pad(east_pad),
        .reg_start_idx(reg_start_idx), .reg_end_idx(reg_end_idx),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Line-buffer banks: data is valid the cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data1 <= bank[0][rd_addr];
            rd_data2 <= bank[1][rd_addr];
            rd_data3 <= bank[2][rd_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] exp_pix(input int r, input int bb, input int rw, input int i);
        int c;
        logic [255:0] w;
        c = rw - 32 * i;
        if (c > 32) c = 32;
        w = bank[r][(bb + i) % 1024];
        for (int p = 0; p < 32; p++)
            if (p >= c) w[p*8 +: 8] = 8'h00;
        return w;
    endfunction

    function automatic logic [15:0] exp_slab(input int r, input int bb, input int rw, input int i, input int sn);
        logic [255:0] prev;
        if (i == 0 || sn == 0) return 16'h0000;
        prev = exp_pix(r, bb, rw, i - 1);
        if (sn == 2) return {prev[255:248], prev[247:240]};
        return {8'h00, prev[255:248]};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; fill_ready = 1'b0;
        k = 4'd0; s = 4'd0; pad = 4'd0; row_width = 16'd0; base_addr = 10'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr, fill_valid, busy, done, west_pad, slab_num, east_pad, reg_start_idx, reg_end_idx} !== 58'd0)
            $display("FAIL reset_ctrl: got %h required 0", {rd_en, rd_addr, fill_valid, busy, done, west_pad, slab_num, east_pad, reg_start_idx, reg_end_idx});
        else n_pass++;
        for (int r = 0; r < 3; r++) begin
            n_checks++;
            if (row_pix[r] !== 256'd0 || row_slab[r] !== 16'd0)
                $display("FAIL reset_data row%0d: pix %h slab %h required 0", r + 1, row_pix[r], row_slab[r]);
            else n_pass++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // mode 0: ready always high; 1: random ready plus ignored starts; 2: stall chunk 0 for 5 cycles
    task automatic run_row(input int kk, input int pp, input int rw, input int bb, input int mode);
        int nch, i, cyc, stall, prev_rise, rd_in_chunk, first_rd, sn, c, e_start, e_end, e_west, e_sn, e_east;
        logic prev_valid;
        logic [9:0] addrs[$];
        logic [9:0] ea;
        nch = (rw + 31) / 32;
        sn  = (kk >= 3) ? 2 : ((kk == 2) ? 1 : 0);
        k = 4'(kk); pad = 4'(pp); row_width = 16'(rw); base_addr = 10'(bb); s = 4'($urandom);
        start = 1'b1; fill_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; i = 0; stall = 0; prev_rise = 0; prev_valid = 1'b0; rd_in_chunk = 0; first_rd = -1;
        while (i < nch && cyc < 400) begin
            if (mode == 1 && $urandom_range(0, 7) == 0) begin
                start = 1'b1; row_width = 16'($urandom); pad = 4'($urandom); k = 4'($urandom);
            end else start = 1'b0;
            if (rd_en) begin
                addrs.push_back(rd_addr);
                if (first_rd < 0) first_rd = cyc;
                if (fill_valid) rd_in_chunk++;
            end
            case (mode)
                0:       fill_ready = 1'b1;
                1:       fill_ready = 1'($urandom_range(0, 1));
                default: fill_ready = (i != 0 || stall >= 5);
            endcase
            if (fill_valid) begin
                if (!prev_valid) begin
                    if (i == 0) begin
                        n_checks++;
                        if (cyc != 3) $display("FAIL first_valid_latency: got cycle %0d required 3", cyc);
                        else n_pass++;
                    end else if (mode == 0) begin
                        n_checks++;
                        if (cyc - prev_rise != GAP) $display("FAIL chunk_gap: got %0d required %0d", cyc - prev_rise, GAP);
                        else n_pass++;
                    end
                    prev_rise = cyc;
                end
                c       = (rw - 32 * i > 32) ? 32 : rw - 32 * i;
                e_west  = (i == 0) ? pp : 0;
                e_sn    = (i == 0) ? 0 : sn;
                e_start = (i == 0) ? pp + 1 : sn + 1;
                e_end   = e_start + c - 1;
                e_east  = (rw - 32 * i <= 32) ? pp : 0;
                n_checks++;
                if (west_pad !== 4'(e_west) || slab_num !== 4'(e_sn) || east_pad !== 4'(e_east))
                    $display("FAIL meta_pad chunk%0d: got w=%0d sn=%0d e=%0d required w=%0d sn=%0d e=%0d",
                             i, west_pad, slab_num, east_pad, e_west, e_sn, e_east);
                else n_pass++;
                n_checks++;
                if (reg_start_idx !== 16'(e_start) || reg_end_idx !== 16'(e_end))
                    $display("FAIL meta_idx chunk%0d: got %0d..%0d required %0d..%0d",
                             i, reg_start_idx, reg_end_idx, e_start, e_end);
                else n_pass++;
                for (int r = 0; r < 3; r++) begin
                    n_checks++;
                    if (row_pix[r] !== exp_pix(r, bb, rw, i))
                        $display("FAIL pixels row%0d chunk%0d: got %h required %h", r + 1, i, row_pix[r], exp_pix(r, bb, rw, i));
                    else n_pass++;
                    n_checks++;
                    if (row_slab[r] !== exp_slab(r, bb, rw, i, sn))
                        $display("FAIL slab row%0d chunk%0d: got %h required %h", r + 1, i, row_slab[r], exp_slab(r, bb, rw, i, sn));
                    else n_pass++;
                end
                if (i == 0) stall++;
                if (fill_ready) begin
                    n_checks++;
                    if (rd_in_chunk != ((PF == 1 && i < nch - 1) ? 1 : 0))
                        $display("FAIL rd_during_hold chunk%0d: got %0d reads", i, rd_in_chunk);
                    else n_pass++;
                    $display("chunk %0d accepted: k=%0d pad=%0d width=%0d idx %0d..%0d", i, kk, pp, rw, reg_start_idx, reg_end_idx);
                    i++;
                    rd_in_chunk = 0;
                end
            end
            prev_valid = fill_valid;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_checks++;
        if (i != nch) $display("FAIL row_timeout: got %0d chunks required %0d", i, nch);
        else n_pass++;
        n_checks++;
        if (first_rd != 1) $display("FAIL rd_latency: got cycle %0d required 1", first_rd);
        else n_pass++;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL done_pulse: got done=%b busy=%b required 1/0", done, busy);
        else n_pass++;
        n_checks++;
        if (addrs.size() != nch) $display("FAIL rd_count: got %0d required %0d", addrs.size(), nch);
        else n_pass++;
        for (int j = 0; j < addrs.size() && j < nch; j++) begin
            ea = 10'((bb + j) % 1024);
            n_checks++;
            if (addrs[j] !== ea) $display("FAIL rd_addr read%0d: got %0d required %0d", j, addrs[j], ea);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_width: got %b required 0", done);
        else n_pass++;
    endtask

    task automatic test_zero_width();
        logic saw;
        k = 4'd3; pad = 4'd1; row_width = 16'd0; base_addr = 10'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({done, rd_en, fill_valid, busy} !== 4'b1000)
            $display("FAIL zero_width: got done/rd/valid/busy=%b required 1000", {done, rd_en, fill_valid, busy});
        else n_pass++;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw = saw | done | rd_en | fill_valid;
        end
        n_checks++;
        if (saw !== 1'b0) $display("FAIL zero_width_after: got activity=%b required 0", saw);
        else n_pass++;
        $display("zero-width row complete");
    endtask

    task automatic test_reset_in_wait();
        logic saw;
        k = 4'd3; pad = 4'd1; row_width = 16'd64; base_addr = 10'd10; fill_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr, fill_valid, busy, done, west_pad, slab_num, east_pad, reg_start_idx, reg_end_idx} !== 58'd0)
            $display("FAIL reset_wait_ctrl: got %h required 0", {rd_en, rd_addr, fill_valid, busy, done, west_pad, slab_num, east_pad, reg_start_idx, reg_end_idx});
        else n_pass++;
        n_checks++;
        if (row1_pixels_32 !== 256'd0 || row2_pixels_32 !== 256'd0 || row3_pixels_32 !== 256'd0)
            $display("FAIL reset_wait_pix: got nonzero pixels %h", row1_pixels_32);
        else n_pass++;
        reset = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            saw = saw | done | fill_valid;
        end
        n_checks++;
        if (saw !== 1'b0) $display("FAIL reset_wait_no_done: got activity=%b required 0", saw);
        else n_pass++;
        $display("reset during WAIT complete");
    endtask

    task automatic test_random_rows();
        for (int t = 0; t < 8; t++)
            run_row($urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(1, 200), $urandom_range(0, 1023), 1);
    endtask

    initial begin
        for (int r = 0; r < 3; r++)
            for (int a = 0; a < 1024; a++)
                for (int w = 0; w < 8; w++)
                    bank[r][a][w*32 +: 32] = $urandom;
        rd_data1 = '0; rd_data2 = '0; rd_data3 = '0;
        test_reset();
        run_row(3, 1, 64, 5, 0);
        run_row(3, 0, 40, 100, 0);
        run_row(1, 2, 96, 1022, 0);
        run_row(2, 1, 96, 50, 2);
        test_zero_width();
        test_reset_in_wait();
        run_row(2, 0, 70, 7, 0);
        test_random_rows();
        run_row(4, 3, 33, 300, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
